int_issue_queue: RTL and testbench

Integer reservation station that sits in front of the issue unit on the integer path. It accepts dispatched integer instructions, snoops the common data bus (CDB) for pending source tags, and captures broadcast results. It presents the oldest instruction whose operands are all valid to the issue unit through ready_int and its operand/tag outputs. The issue unit consumes the entry with issue_int, and later broadcasts the result on the CDB that this block snoops.

---
 rtl/int_issue_queue_if.sv | 42 ++++
 rtl/int_issue_queue.sv | 117 +++++++++++
 tb/tb_int_issue_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/int_issue_queue_if.sv
// Dispatch, CDB, issue and status signals of the integer reservation station.
// master drives requests (dispatch/CDB/issue side), slave is the queue.
interface int_issue_queue_if #(
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
);
    logic              flush;
    logic              dispatch_en;
    logic [3:0]        dispatch_opcode;
    logic [DATA_W-1:0] dispatch_rsdata;
    logic              dispatch_rsvalid;
    logic [TAG_W-1:0]  dispatch_rstag;
    logic [DATA_W-1:0] dispatch_rtdata;
    logic              dispatch_rtvalid;
    logic [TAG_W-1:0]  dispatch_rttag;
    logic [TAG_W-1:0]  dispatch_rdtag;
    logic              queue_full;
    logic [3:0]        entry_count;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tagout;
    logic [DATA_W-1:0] cdb_out;
    logic              ready_int;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] rsdata;
    logic [DATA_W-1:0] rtdata;
    logic [TAG_W-1:0]  rdtag;
    logic              issue_int;

    modport master (
        output flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
               dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
               dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, issue_int,
        input  queue_full, entry_count, ready_int, opcode, rsdata, rtdata, rdtag
    );

    modport slave (
        input  flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
               dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
               dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, issue_int,
        output queue_full, entry_count, ready_int, opcode, rsdata, rtdata, rdtag
    );
endinterface

// File: rtl/int_issue_queue.sv
// Age-ordered integer reservation station: CDB snoop, oldest-ready selection,
// compaction on issue. Slots [0, count) are valid, slot 0 oldest.
module int_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input logic             clk,
    input logic             reset,
    int_issue_queue_if.slave bus_io
);
    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] rs_data;
        logic              rs_vld;
        logic [TAG_W-1:0]  rs_tag;
        logic [DATA_W-1:0] rt_data;
        logic              rt_vld;
        logic [TAG_W-1:0]  rt_tag;
        logic [TAG_W-1:0]  rd_tag;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           snp   [DEPTH];
    entry_t           new_e;
    logic [3:0]       count_q, count_d, wr_idx;
    logic [DEPTH-1:0] rdy, sel_oh;
    logic             any_rdy, full, do_issue, do_disp, seen;

    function automatic entry_t snoop(entry_t e, logic cv, logic [TAG_W-1:0] ct,
                                     logic [DATA_W-1:0] cd);
        entry_t r;
        r = e;
        if (cv && !e.rs_vld && e.rs_tag == ct) begin
            r.rs_data = cd;
            r.rs_vld  = 1'b1;
        end
        if (cv && !e.rt_vld && e.rt_tag == ct) begin
            r.rt_data = cd;
            r.rt_vld  = 1'b1;
        end
        return r;
    endfunction

    // Readiness uses registered operand state only: no CDB-to-issue forwarding.
    always_comb begin
        any_rdy = 1'b0;
        rdy     = '0;
        sel_oh  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rdy[i]    = (4'(i) < count_q) && ent_q[i].rs_vld && ent_q[i].rt_vld;
            sel_oh[i] = rdy[i] && !any_rdy;
            any_rdy   = any_rdy | rdy[i];
        end
    end

    always_comb begin
        bus_io.opcode = '0;
        bus_io.rsdata = '0;
        bus_io.rtdata = '0;
        bus_io.rdtag  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (sel_oh[i]) begin
                bus_io.opcode = ent_q[i].op;
                bus_io.rsdata = ent_q[i].rs_data;
                bus_io.rtdata = ent_q[i].rt_data;
                bus_io.rdtag  = ent_q[i].rd_tag;
            end
        end
    end

    assign full               = (count_q == 4'(DEPTH));
    assign bus_io.queue_full  = full;
    assign bus_io.entry_count = count_q;
    assign bus_io.ready_int   = any_rdy;

    always_comb begin
        do_issue = any_rdy && bus_io.issue_int;
        do_disp  = bus_io.dispatch_en && !full;
        for (int i = 0; i < int'(DEPTH); i++) begin
            snp[i]   = snoop(ent_q[i], bus_io.cdb_valid, bus_io.cdb_tagout, bus_io.cdb_out);
            ent_d[i] = snp[i];
        end
        // Slots at or above the issued one take their younger neighbour.
        seen = 1'b0;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            seen = seen | sel_oh[i];
            if (do_issue && seen) ent_d[i] = snp[i+1];
        end
        new_e = '{op:      bus_io.dispatch_opcode,
                  rs_data: bus_io.dispatch_rsdata,
                  rs_vld:  bus_io.dispatch_rsvalid,
                  rs_tag:  bus_io.dispatch_rstag,
                  rt_data: bus_io.dispatch_rtdata,
                  rt_vld:  bus_io.dispatch_rtvalid,
                  rt_tag:  bus_io.dispatch_rttag,
                  rd_tag:  bus_io.dispatch_rdtag};
        new_e  = snoop(new_e, bus_io.cdb_valid, bus_io.cdb_tagout, bus_io.cdb_out);
        wr_idx = count_q - 4'(do_issue);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (do_disp && 4'(i) == wr_idx) ent_d[i] = new_e;
        end
        count_d = count_q + 4'(do_disp) - 4'(do_issue);
        if (bus_io.flush) count_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: directed vector table, async-reset sequence, then
// random traffic against a queue-based reference model.
module tb_int_issue_queue;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    int_issue_queue_if #(.TAG_W(6), .DATA_W(32)) bus ();

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .DATA_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    typedef struct {
        logic fl, de; logic [3:0] op; logic [31:0] rsd; logic rsv; logic [5:0] rst;
        logic [31:0] rtd; logic rtv; logic [5:0] rtt; logic [5:0] rd;
        logic cv; logic [5:0] ct; logic [31:0] cd; logic iss;
        logic [79:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0] op; logic [31:0] rs; bit rsv; logic [5:0] rst;
        logic [31:0] rt; bit rtv; logic [5:0] rtt; logic [5:0] rd;
    } m_ent_t;

    m_ent_t mq[$];
    vec_t   tbl[$];

    // Expected vector: {ready, full, count, opcode, rsdata, rtdata, rdtag}
    function automatic vec_t v(input logic fl, input logic de, input logic [3:0] op,
                               input logic [31:0] rsd, input logic rsv, input logic [5:0] rst,
                               input logic [31:0] rtd, input logic rtv, input logic [5:0] rtt,
                               input logic [5:0] rd, input logic cv, input logic [5:0] ct,
                               input logic [31:0] cd, input logic iss,
                               input logic er, input logic ef, input logic [3:0] ec,
                               input logic [3:0] eo, input logic [31:0] ers,
                               input logic [31:0] ert, input logic [5:0] erd);
        vec_t r;
        r.fl = fl; r.de = de; r.op = op; r.rsd = rsd; r.rsv = rsv; r.rst = rst;
        r.rtd = rtd; r.rtv = rtv; r.rtt = rtt; r.rd = rd; r.cv = cv; r.ct = ct;
        r.cd = cd; r.iss = iss;
        r.exp = {er, ef, ec, eo, ers, ert, erd};
        return r;
    endfunction

    function automatic logic [79:0] dut_vec();
        return {bus.ready_int, bus.queue_full, bus.entry_count, bus.opcode,
                bus.rsdata, bus.rtdata, bus.rdtag};
    endfunction

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        bus.flush = t.fl; bus.dispatch_en = t.de; bus.dispatch_opcode = t.op;
        bus.dispatch_rsdata = t.rsd; bus.dispatch_rsvalid = t.rsv; bus.dispatch_rstag = t.rst;
        bus.dispatch_rtdata = t.rtd; bus.dispatch_rtvalid = t.rtv; bus.dispatch_rttag = t.rtt;
        bus.dispatch_rdtag = t.rd; bus.cdb_valid = t.cv; bus.cdb_tagout = t.ct;
        bus.cdb_out = t.cd; bus.issue_int = t.iss;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] model_exp();
        logic f;
        f = (mq.size() == DEPTH);
        foreach (mq[i])
            if (mq[i].rsv && mq[i].rtv)
                return {1'b1, f, 4'(mq.size()), mq[i].op, mq[i].rs, mq[i].rt, mq[i].rd};
        return {1'b0, f, 4'(mq.size()), 74'b0};
    endfunction

    task automatic model_step();
        m_ent_t e;
        int     sel;
        bit     was_full;
        if (bus.flush) begin
            mq.delete();
            return;
        end
        was_full = (mq.size() == DEPTH);
        sel = -1;
        foreach (mq[i]) if (sel < 0 && mq[i].rsv && mq[i].rtv) sel = i;
        foreach (mq[i]) begin
            if (bus.cdb_valid && !mq[i].rsv && mq[i].rst == bus.cdb_tagout) begin
                mq[i].rs = bus.cdb_out; mq[i].rsv = 1;
            end
            if (bus.cdb_valid && !mq[i].rtv && mq[i].rtt == bus.cdb_tagout) begin
                mq[i].rt = bus.cdb_out; mq[i].rtv = 1;
            end
        end
        if (bus.issue_int && sel >= 0) mq.delete(sel);
        if (bus.dispatch_en && !was_full) begin
            e.op = bus.dispatch_opcode; e.rd = bus.dispatch_rdtag;
            e.rs = bus.dispatch_rsdata; e.rsv = bus.dispatch_rsvalid; e.rst = bus.dispatch_rstag;
            e.rt = bus.dispatch_rtdata; e.rtv = bus.dispatch_rtvalid; e.rtt = bus.dispatch_rttag;
            if (bus.cdb_valid && !e.rsv && e.rst == bus.cdb_tagout) begin
                e.rs = bus.cdb_out; e.rsv = 1;
            end
            if (bus.cdb_valid && !e.rtv && e.rtt == bus.cdb_tagout) begin
                e.rt = bus.cdb_out; e.rtv = 1;
            end
            mq.push_back(e);
        end
    endtask

    vec_t idle;

    initial begin
        idle = v(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        //       fl de op  rsd         rsv rst rtd  rtv rtt rd cv ct cd           iss
        //       er ef ec eo ers          ert          erd
        tbl.push_back(v(0,1,4'h2,32'h5,1,0,32'h3,1,0,9, 0,0,0,0, 1,0,1,4'h2,32'h5,32'h3,9));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,4'h1,0,0,12,32'h7,1,0,10, 0,0,0,0, 0,0,1,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,1,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,1,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 1,12,32'hDEAD,0, 1,0,1,4'h1,32'hDEAD,32'h7,10));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,4'h3,0,0,7,32'h2,1,0,11, 1,7,32'h1234,0,
                        1,0,1,4'h3,32'h1234,32'h2,11));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,4'h4,0,0,20,32'h1,1,0,1, 0,0,0,0, 0,0,1,0,0,0,0));
        tbl.push_back(v(0,1,4'h5,32'h11,1,0,32'h12,1,0,2, 0,0,0,0, 1,0,2,4'h5,32'h11,32'h12,2));
        tbl.push_back(v(0,1,4'h6,32'h21,1,0,32'h22,1,0,3, 0,0,0,0, 1,0,3,4'h5,32'h11,32'h12,2));
        tbl.push_back(v(0,1,4'h7,32'h31,1,0,32'h32,1,0,4, 0,0,0,0, 1,1,4,4'h5,32'h11,32'h12,2));
        tbl.push_back(v(0,1,4'h8,32'h41,1,0,32'h42,1,0,5, 0,0,0,0, 1,1,4,4'h5,32'h11,32'h12,2));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,1, 1,0,3,4'h6,32'h21,32'h22,3));
        tbl.push_back(v(0,1,4'h8,32'h41,1,0,32'h42,1,0,5, 0,0,0,0, 1,1,4,4'h6,32'h21,32'h22,3));
        tbl.push_back(v(0,1,4'h9,32'h51,1,0,32'h52,1,0,6, 0,0,0,1, 1,0,3,4'h7,32'h31,32'h32,4));
        tbl.push_back(v(0,1,4'h9,32'h51,1,0,32'h52,1,0,6, 0,0,0,0, 1,1,4,4'h7,32'h31,32'h32,4));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,1, 1,0,3,4'h8,32'h41,32'h42,5));
        tbl.push_back(v(1,1,4'hA,32'h61,1,0,32'h62,1,0,8, 1,20,32'h99,1, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,4'hA,0,0,30,0,0,30,7, 0,0,0,0, 0,0,1,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 1,30,32'hBEEF,0, 1,0,1,4'hA,32'hBEEF,32'hBEEF,7));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0,0,0,0));

        apply(idle);
        reset = 1'b1;
        tick();
        tick();
        check("reset_state", dut_vec(), 80'b0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            tick();
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Asynchronous reset in the middle of a cycle with live entries.
        apply(v(0,1,4'hB,32'h71,1,0,32'h72,1,0,12, 0,0,0,0, 0,0,0,0,0,0,0));
        tick();
        tick();
        apply(idle);
        check("pre_async_reset", dut_vec(), {1'b1,1'b0,4'd2,4'hB,32'h71,32'h72,6'd12});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_no_edge", dut_vec(), 80'b0);
        tick();
        check("reset_held", dut_vec(), 80'b0);
        reset = 1'b0;
        mq.delete();

        for (int c = 0; c < 3000; c++) begin
            bus.flush            = ($urandom_range(0, 49) == 0);
            bus.dispatch_en      = ($urandom_range(0, 9) < 6);
            bus.dispatch_opcode  = 4'($urandom);
            bus.dispatch_rsdata  = $urandom;
            bus.dispatch_rsvalid = $urandom_range(0, 1) == 1;
            bus.dispatch_rstag   = 6'($urandom_range(0, 7));
            bus.dispatch_rtdata  = $urandom;
            bus.dispatch_rtvalid = $urandom_range(0, 1) == 1;
            bus.dispatch_rttag   = 6'($urandom_range(0, 7));
            bus.dispatch_rdtag   = 6'($urandom);
            bus.cdb_valid        = ($urandom_range(0, 9) < 4);
            bus.cdb_tagout       = 6'($urandom_range(0, 7));
            bus.cdb_out          = $urandom;
            bus.issue_int        = $urandom_range(0, 1) == 1;
            check($sformatf("rand%0d", c), dut_vec(), model_exp());
            model_step();
            tick();
        end
        check("rand_final", dut_vec(), model_exp());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
